// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch + data) in front of one single-port
// synchronous memory. Each access takes three cycles: grant, memory access, response.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_stall_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_ack_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_stall_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic                  gnt_d_q, gnt_d_d;
  logic                  mem_ce_q, mem_ce_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W/8-1:0]   mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [DATA_W-1:0]     if_data_q, if_data_d;
  logic [DATA_W-1:0]     d_data_q, d_data_d;
  logic                  pick_d;

  // Data wins unless fetch is also waiting and data had the previous grant.
  assign pick_d = d_req_i && (!if_req_i || !last_d_q);

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    gnt_d_d     = gnt_d_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_sel_d   = mem_sel_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_data_d   = if_data_q;
    d_data_d    = d_data_q;
    case (state_q)
      IDLE: if (if_req_i || d_req_i) begin
        state_d  = ACC;
        gnt_d_d  = pick_d;
        last_d_d = pick_d;
        mem_ce_d = 1'b1;
        if (pick_d) begin
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_sel_d   = d_sel_i;
          mem_wdata_d = d_wdata_i;
        end else begin
          mem_addr_d  = if_addr_i;
          mem_sel_d   = '1;
          mem_wdata_d = '0;
        end
      end
      ACC: begin
        state_d  = RESP;
        if_ack_d = !gnt_d_q;
        d_ack_d  = gnt_d_q;
      end
      RESP: begin
        state_d = IDLE;
        // Keep the word seen during the ack so the port holds it afterwards.
        if (if_ack_q) if_data_d = mem_rdata_i;
        if (d_ack_q)  d_data_d  = mem_rdata_i;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      gnt_d_q     <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_data_q   <= '0;
      d_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      gnt_d_q     <= gnt_d_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_data_q   <= if_data_d;
      d_data_q    <= d_data_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_data_o   = if_ack_q ? mem_rdata_i : if_data_q;
  assign d_rdata_o   = d_ack_q  ? mem_rdata_i : d_data_q;
  assign if_stall_o  = if_req_i && !if_ack_q;
  assign d_stall_o   = d_req_i && !d_ack_q;
  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory accesses and acks are queued
// with their cycle numbers and checked by a negedge monitor.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o, if_stall_o;
  logic [31:0] if_data_o;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic [3:0]  d_sel_i = '0;
  logic        d_ack_o, d_stall_o;
  logic [31:0] d_rdata_o;
  logic        mem_ce_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_rdata_i = '0;

  typedef struct {int cyc; logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata;} mem_exp_t;
  typedef struct {int cyc; logic chk_data; logic [31:0] data;} rsp_exp_t;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_if[$];
  rsp_exp_t exp_d[$];

  int n_chk = 0, n_pass = 0, cyc = 0, k = 0;
  logic [31:0] mem [64] = '{4: 32'h0000_0013, default: 32'h0};

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_data_o(if_data_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
    .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory with byte enables.
  always @(posedge clk) begin
    if (mem_ce_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_sel_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= mem[mem_addr_o[7:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_mem(input int c, input logic we, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] w);
    mem_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.sel = s; e.wdata = w;
    exp_mem.push_back(e);
  endtask

  task automatic push_rsp(input logic is_d, input int c, input logic cd, input logic [31:0] dat);
    rsp_exp_t e;
    e.cyc = c; e.chk_data = cd; e.data = dat;
    if (is_d) exp_d.push_back(e);
    else exp_if.push_back(e);
  endtask

  always @(negedge clk) begin
    mem_exp_t me;
    rsp_exp_t re;
    if (rst) begin
      chk("if_stall", {31'b0, if_stall_o}, {31'b0, if_req_i & ~if_ack_o});
      chk("d_stall",  {31'b0, d_stall_o},  {31'b0, d_req_i & ~d_ack_o});
      chk("we_without_ce", {31'b0, mem_we_o & ~mem_ce_o}, 32'd0);
      if (mem_ce_o) begin
        chk("mem_access_expected", {31'b0, exp_mem.size() != 0}, 32'd1);
        if (exp_mem.size() != 0) begin
          me = exp_mem.pop_front();
          chk("mem_cycle", cyc, me.cyc);
          chk("mem_we", {31'b0, mem_we_o}, {31'b0, me.we});
          chk("mem_addr", mem_addr_o, me.addr);
          chk("mem_sel", {28'b0, mem_sel_o}, {28'b0, me.sel});
          chk("mem_wdata", mem_wdata_o, me.wdata);
        end
      end
      if (if_ack_o) begin
        chk("if_ack_expected", {31'b0, exp_if.size() != 0}, 32'd1);
        if (exp_if.size() != 0) begin
          re = exp_if.pop_front();
          chk("if_ack_cycle", cyc, re.cyc);
          if (re.chk_data) chk("if_data", if_data_o, re.data);
        end
      end
      if (d_ack_o) begin
        chk("d_ack_expected", {31'b0, exp_d.size() != 0}, 32'd1);
        if (exp_d.size() != 0) begin
          re = exp_d.pop_front();
          chk("d_ack_cycle", cyc, re.cyc);
          if (re.chk_data) chk("d_rdata", d_rdata_o, re.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    // Outputs held at zero while reset is low.
    #12;
    chk("rst_if_ack", {31'b0, if_ack_o}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack_o}, 32'd0);
    chk("rst_mem_ce", {31'b0, mem_ce_o}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_d_rdata", d_rdata_o, 32'd0);
    wait_edges(1);
    rst = 1'b1;

    // Fetch only: access at N+1, ack with 0x13 at N+2, stalled in N and N+1.
    wait_edges(1);
    k = cyc; if_req_i = 1'b1; if_addr_i = 32'h10;
    push_mem(k + 1, 1'b0, 32'h10, 4'hF, 32'h0);
    push_rsp(1'b0, k + 2, 1'b1, 32'h13);
    #2 chk("fetch_stall_N", {31'b0, if_stall_o}, 32'd1);
    wait_edges(1); #2 chk("fetch_stall_N1", {31'b0, if_stall_o}, 32'd1);
    wait_edges(1); #2 chk("fetch_stall_N2", {31'b0, if_stall_o}, 32'd0);
    wait_edges(1); if_req_i = 1'b0;

    // Partial write, zero-select write, then read back.
    wait_edges(1);
    k = cyc; d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_sel_i = 4'b0011; d_wdata_i = 32'hDEADBEEF;
    push_mem(k + 1, 1'b1, 32'h20, 4'b0011, 32'hDEADBEEF);
    push_rsp(1'b1, k + 2, 1'b0, 32'h0);
    wait_edges(3); d_req_i = 1'b0;
    wait_edges(1);
    k = cyc; d_req_i = 1'b1; d_sel_i = 4'b0000; d_wdata_i = 32'hFFFFFFFF;
    push_mem(k + 1, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
    push_rsp(1'b1, k + 2, 1'b0, 32'h0);
    wait_edges(3); d_req_i = 1'b0;
    wait_edges(1);
    k = cyc; d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_wdata_i = 32'h0;
    push_mem(k + 1, 1'b0, 32'h20, 4'hF, 32'h0);
    push_rsp(1'b1, k + 2, 1'b1, 32'h0000BEEF);
    wait_edges(3); d_req_i = 1'b0;

    // Both held out of reset: data, fetch, data, fetch, 3 cycles apart.
    rst = 1'b0;
    wait_edges(1);
    rst = 1'b1;
    wait_edges(1);
    k = cyc; if_req_i = 1'b1; if_addr_i = 32'h10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20; d_sel_i = 4'hF; d_wdata_i = 32'h0;
    push_mem(k + 1,  1'b0, 32'h20, 4'hF, 32'h0);
    push_mem(k + 4,  1'b0, 32'h10, 4'hF, 32'h0);
    push_mem(k + 7,  1'b0, 32'h20, 4'hF, 32'h0);
    push_mem(k + 10, 1'b0, 32'h10, 4'hF, 32'h0);
    push_rsp(1'b1, k + 2,  1'b1, 32'h0000BEEF);
    push_rsp(1'b0, k + 5,  1'b1, 32'h13);
    push_rsp(1'b1, k + 8,  1'b1, 32'h0000BEEF);
    push_rsp(1'b0, k + 11, 1'b1, 32'h13);
    wait_edges(12); if_req_i = 1'b0; d_req_i = 1'b0;

    // Data req dropped in ACC still completes; a fetch right after shows IDLE.
    wait_edges(1);
    k = cyc; d_req_i = 1'b1; d_addr_i = 32'h10;
    push_mem(k + 1, 1'b0, 32'h10, 4'hF, 32'h0);
    push_rsp(1'b1, k + 2, 1'b1, 32'h13);
    wait_edges(1); d_req_i = 1'b0;
    wait_edges(2);
    if_req_i = 1'b1; if_addr_i = 32'h20;
    push_mem(k + 4, 1'b0, 32'h20, 4'hF, 32'h0);
    push_rsp(1'b0, k + 5, 1'b1, 32'h0000BEEF);
    wait_edges(3); if_req_i = 1'b0;

    // Reset during the ACC of a write abandons it.
    wait_edges(1);
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h30; d_sel_i = 4'hF; d_wdata_i = 32'h12345678;
    wait_edges(1);
    #1;
    chk("acc_mem_ce", {31'b0, mem_ce_o}, 32'd1);
    chk("acc_mem_we", {31'b0, mem_we_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_acc_mem_ce", {31'b0, mem_ce_o}, 32'd0);
    chk("rst_acc_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_acc_d_ack", {31'b0, d_ack_o}, 32'd0);
    d_req_i = 1'b0; d_we_i = 1'b0;
    wait_edges(1);
    rst = 1'b1;
    wait_edges(1);
    k = cyc; if_req_i = 1'b1; if_addr_i = 32'h30;
    push_mem(k + 1, 1'b0, 32'h30, 4'hF, 32'h0);
    push_rsp(1'b0, k + 2, 1'b1, 32'h0);
    wait_edges(3); if_req_i = 1'b0;

    wait_edges(4);
    chk("mem_queue_drained", exp_mem.size(), 32'd0);
    chk("if_queue_drained", exp_if.size(), 32'd0);
    chk("d_queue_drained", exp_d.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of every address bus.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of every data bus; the byte-select width is DATA_W/8.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 if_req_i  in  1  instruction-fetch request; if_addr_i  in  ADDR_W  fetch address.
REQ-006 if_ack_o  out  1  one-cycle fetch completion; if_data_o  out  DATA_W  fetched word.
REQ-007 if_stall_o  out  1  fetch port stalled.
REQ-008 d_req_i  in  1  data request; d_we_i  in  1  write enable; d_addr_i  in  ADDR_W; d_sel_i  in  DATA_W/8  byte select; d_wdata_i  in  DATA_W.
REQ-009 d_ack_o  out  1  one-cycle data completion; d_rdata_o  out  DATA_W; d_stall_o  out  1  data port stalled.
REQ-010 mem_ce_o, mem_we_o  out  1; mem_addr_o  out  ADDR_W; mem_sel_o  out  DATA_W/8; mem_wdata_o  out  DATA_W; mem_rdata_i  in  DATA_W. This is the single-port synchronous memory, read data valid in the cycle after the sampling edge.

Function
REQ-011 The block SHALL share one memory port between the fetch and data requesters, one access at a time.
REQ-012 FSM states SHALL be IDLE, ACC, RESP; transitions: IDLE->ACC when any req is high; ACC->RESP always; RESP->IDLE always.
REQ-013 In IDLE with a req high, the grant SHALL be latched at the clock edge, along with the granted port's addr/we/sel/wdata.
REQ-014 Priority SHALL be data over fetch, except that when both request and the previous grant was data, fetch wins (alternation, no starvation).
REQ-015 The last-grant register SHALL update on every grant; reset value = fetch, so the first simultaneous request goes to data.
REQ-016 mem_* outputs SHALL be registered and valid only in ACC: mem_ce_o=1, with addr/we/sel/wdata from the latched request; in IDLE and RESP, mem_ce_o=0 and mem_we_o=0.
REQ-017 A fetch grant SHALL drive mem_we_o=0 and mem_sel_o all ones; a data grant SHALL drive d_we_i and d_sel_i unchanged, including sel=0.
REQ-018 In RESP, the granted port's ack SHALL be 1 for exactly one cycle, with its data output = mem_rdata_i; for a write, the data output is don't-care.
REQ-019 Latency from req sampled in IDLE to ack SHALL be 2 cycles (edge N grant, ACC, RESP); throughput SHALL be one access per 3 cycles.
REQ-020 The ungranted port's ack SHALL stay 0; its data output SHALL hold its last value.
REQ-021 if_stall_o SHALL equal if_req_i AND NOT if_ack_o, and d_stall_o SHALL equal d_req_i AND NOT d_ack_o; both are combinational.
REQ-022 Requesters SHALL hold req and all request fields stable until ack; a req still high in the cycle after ack is a new request.
REQ-023 If req drops during ACC or RESP, the access SHALL still complete and ack still pulse; the requester ignores it.
REQ-024 Request-field changes after the grant edge SHALL NOT affect the in-flight access.

Reset
REQ-025 While rst=0, state SHALL be IDLE, last grant = fetch, all ack/mem_ce_o/mem_we_o = 0, and all data/address outputs = 0, asynchronously.
REQ-026 Reset asserted in ACC SHALL immediately deassert mem_ce_o and mem_we_o; the in-flight access is abandoned and no ack issues.
REQ-027 After rst rises, the first arbitration SHALL occur on the first edge at which a req is high in IDLE.

Verification
REQ-028 Fetch only: if_req_i=1, if_addr_i=0x10, memory word 0x00000013 -> mem_ce_o=1 and addr 0x10 in cycle N+1, if_ack_o=1 and if_data_o=0x13 in N+2, if_stall_o=1 in N and N+1.
REQ-029 Data write: d_we_i=1, addr 0x20, sel 4'b0011, wdata 0xDEADBEEF -> mem_we_o=1 and mem_sel_o=0011 in ACC, d_ack_o pulse in RESP; a later read of 0x20 returns 0x0000BEEF on zero-initialised memory.
REQ-030 Simultaneous requests held high out of reset -> grant order data, fetch, data, fetch; each ack every 3 cycles; neither port waits more than 6 cycles.
REQ-031 Data req dropped in ACC -> memory access still issued, d_ack_o still pulses once, FSM back in IDLE next cycle.
REQ-032 rst=0 asserted mid-ACC of a write -> mem_we_o and mem_ce_o go to 0 before the next edge, no ack issued; after release, a new fetch completes with normal 2-cycle latency.
